// File: rtl/grid_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// grid_write_arbiter_if : player request/ack, clear control and grid RAM port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface grid_write_arbiter_if;
  logic        p0_req;
  logic        p1_req;
  logic [11:0] p0_addr;
  logic [11:0] p1_addr;
  logic [3:0]  p0_data;
  logic [3:0]  p1_data;
  logic        p0_ack;
  logic        p1_ack;
  logic        p0_hit;
  logic        p1_hit;
  logic        clr_start;
  logic [3:0]  clr_color;
  logic        clr_done;
  logic [3:0]  color_data_in;
  logic        wren_gridData;
  logic [3:0]  data_gridData;
  logic [11:0] wraddress_gridData;
  logic        busy;

  modport slave (
    input  p0_req, p1_req, p0_addr, p1_addr, p0_data, p1_data,
    input  clr_start, clr_color, color_data_in,
    output p0_ack, p1_ack, p0_hit, p1_hit, clr_done,
    output wren_gridData, data_gridData, wraddress_gridData, busy
  );

  modport master (
    output p0_req, p1_req, p0_addr, p1_addr, p0_data, p1_data,
    output clr_start, clr_color, color_data_in,
    input  p0_ack, p1_ack, p0_hit, p1_hit, clr_done,
    input  wren_gridData, data_gridData, wraddress_gridData, busy
  );
endinterface

`default_nettype wire

// File: rtl/grid_write_arbiter.sv
// ----------------------------------------------------------------------------
// grid_write_arbiter : round-robin two-player grid-cell writer with full-grid clear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module grid_write_arbiter (
  input  wire                  iVGA_CLK,
  input  wire                  iRST_n,
  grid_write_arbiter_if.slave  bus_if
);

  localparam logic [11:0] c_FIRST_OFFGRID = 12'd3072;
  localparam logic [11:0] c_LAST_CELL     = 12'd4095;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROBE = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    HIT   = 3'd4,
    CLEAR = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;          // 0 = p0 owns the access, 1 = p1
  logic        last_q, last_d;        // requester acked most recently
  logic [11:0] addr_q, addr_d;
  logic [3:0]  data_q, data_d;
  logic        pend_q, pend_d;
  logic [3:0]  clr_color_q, clr_color_d;
  logic [11:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        w_grant_p1;

  // p1 wins alone, or in a tie when p0 was the one served last
  assign w_grant_p1 = bus_if.p1_req && (!bus_if.p0_req || !last_q);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_d      = pend_q;
    clr_color_d = clr_color_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    if (bus_if.clr_start && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus_if.clr_start || pend_q) begin
          state_d     = CLEAR;
          pend_d      = 1'b0;
          cnt_d       = 12'd0;
          clr_color_d = bus_if.clr_color;
        end else if (bus_if.p0_req || bus_if.p1_req) begin
          state_d = PROBE;
          win_d   = w_grant_p1;
          addr_d  = w_grant_p1 ? bus_if.p1_addr : bus_if.p0_addr;
          data_d  = w_grant_p1 ? bus_if.p1_data : bus_if.p0_data;
        end
      end
      PROBE: state_d = CHECK;
      CHECK: begin
        if ((addr_q >= c_FIRST_OFFGRID) || (bus_if.color_data_in != 4'd0)) begin
          state_d = HIT;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE, HIT: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      CLEAR: begin
        if (cnt_q == c_LAST_CELL) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= 12'd0;
      data_q      <= 4'd0;
      pend_q      <= 1'b0;
      clr_color_q <= 4'd0;
      cnt_q       <= 12'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      clr_color_q <= clr_color_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  // Outputs decode only from state and latched registers
  assign bus_if.busy               = (state_q != IDLE);
  assign bus_if.wren_gridData      = (state_q == WRITE) || (state_q == CLEAR);
  assign bus_if.wraddress_gridData = (state_q == CLEAR) ? cnt_q : addr_q;
  assign bus_if.data_gridData      = (state_q == CLEAR) ? clr_color_q : data_q;
  assign bus_if.p0_ack             = ((state_q == WRITE) || (state_q == HIT)) && !win_q;
  assign bus_if.p1_ack             = ((state_q == WRITE) || (state_q == HIT)) &&  win_q;
  assign bus_if.p0_hit             = (state_q == HIT) && !win_q;
  assign bus_if.p1_hit             = (state_q == HIT) &&  win_q;
  assign bus_if.clr_done           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_grid_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_grid_write_arbiter : directed stimulus, job-level reference model, grid RAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_grid_write_arbiter;

  logic iVGA_CLK = 1'b0;
  logic iRST_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  grid_write_arbiter_if bus_if ();

  grid_write_arbiter dut (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .bus_if   (bus_if)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;
  always @(posedge iVGA_CLK) cyc <= cyc + 1;

  // Grid RAM: write port plus registered read port B at the same address
  logic [3:0] ram [0:4095];
  bit         ram_init = 1'b0;
  always @(posedge iVGA_CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] = 4'd0;
      ram_init = 1'b1;
    end
    bus_if.color_data_in <= ram[bus_if.wraddress_gridData];
    if (bus_if.wren_gridData) ram[bus_if.wraddress_gridData] <= bus_if.data_gridData;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one job at a time (player access = 3 busy cycles, clear = 4096)
  int         m_kind = 0;    // 0 none, 1 player access, 2 clear sweep
  int         m_step = 0;
  int         m_win = 0;
  int         m_favor = 0;
  logic [11:0] m_addr = '0;
  logic [3:0] m_data = '0;
  logic [3:0] m_ccol = '0;
  bit         m_hit = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_done = 1'b0;
  logic [3:0] m_grid [0:4095];
  bit         m_init = 1'b0;

  always @(negedge iVGA_CLK) begin
    logic [6:0] act_v, exp_v;
    bit e_ack, e_wren;
    if (!m_init) begin
      for (int i = 0; i < 4096; i++) m_grid[i] = 4'd0;
      m_init = 1'b1;
    end
    act_v = {bus_if.busy, bus_if.wren_gridData, bus_if.p0_ack, bus_if.p0_hit,
             bus_if.p1_ack, bus_if.p1_hit, bus_if.clr_done};
    if (!iRST_n) begin
      m_kind = 0; m_step = 0; m_favor = 0; m_pend = 1'b0; m_done = 1'b0;
      chk("reset_ctrl", int'(act_v), 0);
      chk("reset_waddr", int'(bus_if.wraddress_gridData), 0);
      chk("reset_wdata", int'(bus_if.data_gridData), 0);
    end else begin
      e_ack  = (m_kind == 1) && (m_step == 3);
      e_wren = (m_kind == 2) || (e_ack && !m_hit);
      exp_v  = {m_kind != 0, e_wren, e_ack && m_win == 0, e_ack && m_win == 0 && m_hit,
                e_ack && m_win == 1, e_ack && m_win == 1 && m_hit, m_done};
      chk("ctrl{busy,wren,a0,h0,a1,h1,done}", int'(act_v), int'(exp_v));
      if (m_kind == 1) chk("access_waddr", int'(bus_if.wraddress_gridData), int'(m_addr));
      if (m_kind == 2) chk("clear_waddr", int'(bus_if.wraddress_gridData), m_step - 1);
      if (e_wren) chk("wdata", int'(bus_if.data_gridData), (m_kind == 2) ? int'(m_ccol) : int'(m_data));

      m_done = 1'b0;
      if (m_kind == 0) begin
        if (bus_if.clr_start || m_pend) begin
          m_kind = 2; m_step = 1; m_ccol = bus_if.clr_color; m_pend = 1'b0;
        end else if (bus_if.p0_req || bus_if.p1_req) begin
          m_win  = (bus_if.p0_req && bus_if.p1_req) ? m_favor : (bus_if.p1_req ? 1 : 0);
          m_addr = m_win ? bus_if.p1_addr : bus_if.p0_addr;
          m_data = m_win ? bus_if.p1_data : bus_if.p0_data;
          m_hit  = (m_addr >= 12'd3072) || (m_grid[m_addr] != 4'd0);
          m_kind = 1; m_step = 1;
        end
      end else begin
        if (bus_if.clr_start) m_pend = 1'b1;
        if (m_kind == 1) begin
          if (m_step == 3) begin
            if (!m_hit) m_grid[m_addr] = m_data;
            m_favor = 1 - m_win;
            m_kind  = 0;
          end else begin
            m_step++;
          end
        end else begin
          m_grid[m_step - 1] = m_ccol;
          if (m_step == 4096) begin
            m_kind = 0; m_done = 1'b1;
          end else begin
            m_step++;
          end
        end
      end
    end
  end

  task automatic do_req(input int p, input logic [11:0] a, input logic [3:0] d,
                        output bit got, output int lat, output bit hit,
                        output bit wr, output int wa, output int wd);
    int t0;
    @(posedge iVGA_CLK); #1;
    if (p == 0) begin
      bus_if.p0_req = 1'b1; bus_if.p0_addr = a; bus_if.p0_data = d;
    end else begin
      bus_if.p1_req = 1'b1; bus_if.p1_addr = a; bus_if.p1_data = d;
    end
    t0 = cyc; got = 1'b0; lat = 0; hit = 1'b0; wr = 1'b0; wa = 0; wd = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge iVGA_CLK);
      if ((p == 0) ? bus_if.p0_ack : bus_if.p1_ack) begin
        got = 1'b1;
        lat = cyc - t0 + 1;
        hit = (p == 0) ? bus_if.p0_hit : bus_if.p1_hit;
        wr  = bus_if.wren_gridData;
        wa  = int'(bus_if.wraddress_gridData);
        wd  = int'(bus_if.data_gridData);
      end
    end
    @(posedge iVGA_CLK); #1;
    bus_if.p0_req = 1'b0; bus_if.p1_req = 1'b0;
  endtask

  // Both requesters held continuously; acks must alternate starting with p0
  task automatic run_both(input string tag, input int n, input logic [11:0] a0, input logic [11:0] a1);
    int seq_i, last_cyc, k0, k1;
    bit s0, s1;
    @(posedge iVGA_CLK); #1;
    bus_if.p0_req = 1'b1; bus_if.p1_req = 1'b1;
    bus_if.p0_addr = a0;  bus_if.p1_addr = a1;
    bus_if.p0_data = 4'd3; bus_if.p1_data = 4'd4;
    seq_i = 0; last_cyc = 0; k0 = 0; k1 = 0;
    for (int i = 0; i < 8 * n && seq_i < n; i++) begin
      @(negedge iVGA_CLK);
      s0 = bus_if.p0_ack; s1 = bus_if.p1_ack;
      if (s0 || s1) begin
        chk({tag, "_order"}, s1 ? 1 : 0, seq_i % 2);
        if (seq_i > 0) chk({tag, "_spacing"}, cyc - last_cyc, 4);
        last_cyc = cyc;
        seq_i++;
      end
      @(posedge iVGA_CLK); #1;
      if (s0) begin k0++; bus_if.p0_addr = a0 + 12'(k0); end
      if (s1) begin k1++; bus_if.p1_addr = a1 + 12'(k1); end
    end
    bus_if.p0_req = 1'b0; bus_if.p1_req = 1'b0;
    chk({tag, "_ack_count"}, seq_i, n);
  endtask

  initial begin
    bit got, hit, wr, p0_got, p1_got, p1h, drop0, seen;
    int lat, wa, wd, n_clr, n_done, seq_err, exp_a, done_cyc, p1_cyc;

    iRST_n = 1'b0;
    bus_if.p0_req = 1'b0; bus_if.p1_req = 1'b0;
    bus_if.p0_addr = '0;  bus_if.p1_addr = '0;
    bus_if.p0_data = '0;  bus_if.p1_data = '0;
    bus_if.clr_start = 1'b0; bus_if.clr_color = '0;
    repeat (3) @(posedge iVGA_CLK);
    #1 iRST_n = 1'b1;
    @(negedge iVGA_CLK);
    chk("post_reset_busy", int'(bus_if.busy), 0);

    // Empty cell written by p0 in the 4th cycle
    do_req(0, 12'h041, 4'd5, got, lat, hit, wr, wa, wd);
    chk("t030_ack", got, 1);  chk("t030_latency", lat, 4);  chk("t030_hit", hit, 0);
    chk("t030_wren", wr, 1);  chk("t030_waddr", wa, 'h041); chk("t030_wdata", wd, 5);
    chk("t030_ram", int'(ram[12'h041]), 5);

    // Occupied cell refused for p1
    do_req(1, 12'h041, 4'd9, got, lat, hit, wr, wa, wd);
    chk("t031_ack", got, 1);  chk("t031_latency", lat, 4);  chk("t031_hit", hit, 1);
    chk("t031_wren", wr, 0);  chk("t031_ram", int'(ram[12'h041]), 5);

    run_both("t032", 6, 12'h100, 12'h200);

    // Grid boundary
    do_req(0, 12'd3072, 4'd2, got, lat, hit, wr, wa, wd);
    chk("t033_offgrid_hit", hit, 1); chk("t033_offgrid_wren", wr, 0);
    do_req(0, 12'd3071, 4'd6, got, lat, hit, wr, wa, wd);
    chk("t033_edge_hit", hit, 0); chk("t033_edge_ram", int'(ram[12'd3071]), 6);

    // Clear requested while p0 is in PROBE, p1 waiting
    @(posedge iVGA_CLK); #1;
    bus_if.p0_req = 1'b1; bus_if.p0_addr = 12'h0A0; bus_if.p0_data = 4'd7;
    @(posedge iVGA_CLK); #1;
    chk("t034_busy_in_probe", int'(bus_if.busy), 1);
    bus_if.clr_start = 1'b1; bus_if.clr_color = 4'd0;
    bus_if.p1_req = 1'b1; bus_if.p1_addr = 12'h0B0; bus_if.p1_data = 4'd3;
    @(posedge iVGA_CLK); #1;
    bus_if.clr_start = 1'b0;
    p0_got = 1'b0; p1_got = 1'b0; p1h = 1'b0; drop0 = 1'b0;
    n_clr = 0; n_done = 0; seq_err = 0; exp_a = 0; done_cyc = 0; p1_cyc = 0;
    for (int i = 0; i < 4200 && !p1_got; i++) begin
      @(negedge iVGA_CLK);
      if (bus_if.p0_ack) begin p0_got = 1'b1; drop0 = 1'b1; end
      if (bus_if.wren_gridData && !bus_if.p0_ack && !bus_if.p1_ack) begin
        if (int'(bus_if.wraddress_gridData) != exp_a || bus_if.data_gridData != 4'd0) seq_err++;
        exp_a++; n_clr++;
      end
      if (bus_if.clr_done) begin n_done++; done_cyc = cyc; end
      if (bus_if.p1_ack) begin p1_got = 1'b1; p1_cyc = cyc; p1h = bus_if.p1_hit; end
      @(posedge iVGA_CLK); #1;
      if (drop0) begin bus_if.p0_req = 1'b0; drop0 = 1'b0; end
    end
    bus_if.p1_req = 1'b0;
    chk("t034_p0_ack", p0_got, 1);      chk("t034_clear_writes", n_clr, 4096);
    chk("t034_clear_order", seq_err, 0); chk("t034_done_pulses", n_done, 1);
    chk("t034_p1_ack", p1_got, 1);      chk("t034_p1_after_done", p1_cyc - done_cyc + 1, 4);
    chk("t034_p1_hit", p1h, 0);
    chk("t034_ram_wiped", int'(ram[12'h0A0]), 0); chk("t034_ram_p1", int'(ram[12'h0B0]), 3);

    // Reset in the middle of a clear sweep; pointer must favour p0 afterwards
    do_req(0, 12'h300, 4'd1, got, lat, hit, wr, wa, wd);
    chk("t035_pre_ack", got, 1);
    @(posedge iVGA_CLK); #1;
    bus_if.clr_start = 1'b1; bus_if.clr_color = 4'd9;
    @(posedge iVGA_CLK); #1;
    bus_if.clr_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge iVGA_CLK);
      if (bus_if.wren_gridData && bus_if.wraddress_gridData == 12'd100) seen = 1'b1;
    end
    chk("t035_reached_100", seen, 1);
    #1 iRST_n = 1'b0;
    #1;
    chk("t035_busy", int'(bus_if.busy), 0);
    chk("t035_wren", int'(bus_if.wren_gridData), 0);
    chk("t035_waddr", int'(bus_if.wraddress_gridData), 0);
    chk("t035_wdata", int'(bus_if.data_gridData), 0);
    chk("t035_done", int'(bus_if.clr_done), 0);
    repeat (2) @(posedge iVGA_CLK);
    #1 iRST_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iVGA_CLK);
      if (bus_if.clr_done) n_done++;
    end
    chk("t035_no_done", n_done, 0);
    run_both("t035", 2, 12'h400, 12'h500);

    repeat (3) @(posedge iVGA_CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
